// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle for alu_seq.
interface alu_seq_if #(parameter int XLEN = 32);
  logic            in_valid, in_ready, out_valid, out_ready, zero;
  logic [4:0]      op;
  logic [XLEN-1:0] a, b, result;
  modport master(output in_valid, op, a, b, out_ready, input in_ready, out_valid, result, zero);
  modport slave(input in_valid, op, a, b, out_ready, output in_ready, out_valid, result, zero);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle ops, shift-add multiply and restoring divide.
module alu_seq #(parameter int XLEN = 32) (
  input logic clk,
  input logic reset,
  alu_seq_if.slave bus
);
  localparam int LW = $clog2(XLEN);
  localparam int CW = LW + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t            r_state;
  logic              r_op0, r_op2, r_out_valid, r_zero;
  logic [XLEN-1:0]   r_a, r_b, r_result;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              w_is_mul, w_is_div, w_last, w_sa, w_sb, w_dok;
  logic [XLEN-1:0]   w_alu, w_bm, w_ddiff, w_qs, w_rs, w_div_res, w_fin;
  logic [XLEN:0]     w_msum, w_dsh;
  logic [2*XLEN-1:0] w_mul_nx, w_div_nx;
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
    return (s && v[XLEN-1]) ? -v : v;
  endfunction
  assign w_is_mul = bus.op == 5'h10 || bus.op == 5'h11;
  assign w_is_div = bus.op >= 5'h12 && bus.op <= 5'h15;
  always_comb begin
    w_alu = '0;
    case (bus.op)
      5'h00: w_alu = bus.a + bus.b;
      5'h01: w_alu = bus.a - bus.b;
      5'h02: w_alu = bus.a & bus.b;
      5'h03: w_alu = bus.a | bus.b;
      5'h04: w_alu = bus.a ^ bus.b;
      5'h05: w_alu = XLEN'($signed(bus.a) < $signed(bus.b));
      5'h06: w_alu = XLEN'(bus.a < bus.b);
      5'h07: w_alu = {bus.a[XLEN-1:12], 12'b0};
      5'h08: w_alu = bus.a + {bus.b[XLEN-1:12], 12'b0};
      5'h09: w_alu = {bus.b[XLEN-1:12], 12'b0};
      5'h0A: w_alu = bus.a << bus.b[LW-1:0];
      5'h0B: w_alu = $signed(bus.a) >>> bus.b[LW-1:0];
      5'h0C: w_alu = bus.a >> bus.b[LW-1:0];
      default: w_alu = '0;
    endcase
  end
  // multiply: multiplier sits in the low half and is consumed LSB first
  assign w_msum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_nx = {w_msum, r_acc[XLEN-1:1]};
  // divide: upper half is the partial remainder, lower half shifts dividend out / quotient in
  assign w_bm     = mag(r_b, !r_op0);
  assign w_dsh    = r_acc[2*XLEN-1:XLEN-1];
  assign w_dok    = w_dsh >= {1'b0, w_bm};
  assign w_ddiff  = w_dsh[XLEN-1:0] - w_bm;
  assign w_div_nx = w_dok ? {w_ddiff, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};
  assign w_sa      = !r_op0 && r_a[XLEN-1];
  assign w_sb      = !r_op0 && r_b[XLEN-1];
  assign w_qs      = (w_sa ^ w_sb) ? -w_div_nx[XLEN-1:0] : w_div_nx[XLEN-1:0];
  assign w_rs      = w_sa ? -w_div_nx[2*XLEN-1:XLEN] : w_div_nx[2*XLEN-1:XLEN];
  assign w_div_res = (r_b == '0) ? (r_op2 ? r_a : '1) : (r_op2 ? w_rs : w_qs);
  assign w_fin     = (r_state == MUL) ? (r_op0 ? w_mul_nx[2*XLEN-1:XLEN] : w_mul_nx[XLEN-1:0]) : w_div_res;
  assign w_last    = r_cnt == CW'(XLEN-1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_cnt       <= '0;
      r_op0       <= 1'b0;
      r_op2       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_op0 <= bus.op[0];
          r_op2 <= bus.op[2];
          r_a   <= bus.a;
          r_b   <= bus.b;
          r_cnt <= '0;
          if (w_is_mul) begin
            r_state <= MUL;
            r_acc   <= {{XLEN{1'b0}}, bus.b};
          end else if (w_is_div) begin
            r_state <= DIV;
            r_acc   <= {{XLEN{1'b0}}, mag(bus.a, !bus.op[0])};
          end else begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_alu;
            r_zero      <= w_alu == '0;
          end
        end
        MUL, DIV: begin
          r_cnt <= r_cnt + CW'(1);
          r_acc <= (r_state == MUL) ? w_mul_nx : w_div_nx;
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_fin;
            r_zero      <= w_fin == '0;
          end
        end
        DONE: if (bus.out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
  assign bus.in_ready  = r_state == IDLE;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two, 16..64.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  operation request.
REQ-005 Port in_ready  output  1  block can accept a request this cycle.
REQ-006 Port op  input  5  operation select, encoding per REQ-011.
REQ-007 Port a, b  input  XLEN each  operands, two's complement where signed.
REQ-008 Port out_valid  output  1  result and zero valid.
REQ-009 Port out_ready  input  1  consumer accepts result.
REQ-010 Port result  output  XLEN; port zero  output  1  (result == 0).

Function
REQ-011 op codes: 00 add, 01 sub, 02 and, 03 or, 04 xor, 05 slt (signed), 06 sltu, 07 {a[XLEN-1:12],0}, 08 auipc a+{b[XLEN-1:12],0}, 09 lui {b[XLEN-1:12],0}, 0A sll, 0B sra, 0C srl, 10 mul (low XLEN), 11 mulhu (high XLEN, unsigned), 12 div, 13 divu, 14 rem, 15 remu; all other codes SHALL return result 0.
REQ-012 Shifts SHALL use only b[log2(XLEN)-1:0] as shift amount; sra SHALL replicate a[XLEN-1].
REQ-013 Handshake: a request is accepted on a rising edge with in_valid && in_ready; op, a, b SHALL be captured at acceptance and later input changes ignored.
REQ-014 FSM states IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE + accept of op 00-0C or undefined code -> DONE with result registered; out_valid SHALL rise one cycle after acceptance.
REQ-016 IDLE + accept of op 10/11 -> MUL: unsigned shift-add, one multiplier bit per cycle, 2*XLEN-bit accumulator, exactly XLEN cycles, then DONE; out_valid rises XLEN+1 cycles after acceptance.
REQ-017 IDLE + accept of op 12-15 -> DIV: restoring division on magnitudes, one quotient bit per cycle, exactly XLEN cycles, then DONE; signed ops SHALL fix signs at DONE entry (quotient negative iff operand signs differ, remainder takes dividend sign); out_valid rises XLEN+1 cycles after acceptance.
REQ-018 Divide by zero: quotient all-ones, remainder = dividend; latency unchanged.
REQ-019 Signed overflow (div/rem of most-negative by -1): quotient = most-negative, remainder 0; latency unchanged.
REQ-020 DONE: out_valid=1, result and zero stable until out_ready=1; on out_valid && out_ready -> IDLE; no new request accepted in the same cycle (in_ready low in DONE).
REQ-021 out_valid SHALL be 0 in IDLE, MUL, DIV; result and zero SHALL hold last delivered value outside DONE.
REQ-022 Iteration counter SHALL be log2(XLEN)+1 bits; no wrap-around beyond XLEN iterations.

Reset
REQ-023 reset asserted SHALL immediately force state IDLE, out_valid 0, result 0, zero 1, counter 0, in_ready 1 after deassertion, regardless of state (including mid MUL/DIV).
REQ-024 An operation interrupted by reset SHALL produce no out_valid pulse afterwards.

Verification
REQ-025 XLEN=32: op 01, a=5, b=5 -> out_valid next cycle, result 0, zero 1; held 3 cycles with out_ready=0, then released.
REQ-026 op 10, a=0xFFFFFFFF, b=2 -> out_valid at acceptance+33, result 0xFFFFFFFE; op 11 same operands -> result 0x00000001.
REQ-027 op 12, a=-7, b=2 -> result 0xFFFFFFFD (-3); op 14 -> 0xFFFFFFFF (-1); op 13, a=7, b=0 -> 0xFFFFFFFF; op 15, a=7, b=0 -> 7.
REQ-028 op 12, a=0x80000000, b=0xFFFFFFFF -> 0x80000000; op 14 same -> 0.
REQ-029 Accept op 12 then assert reset at acceptance+10 -> out_valid stays 0, in_ready 1 after reset; next op 00, a=1, b=2 -> result 3.
REQ-030 op 0B, a=0x80000000, b=0x21 -> 0xC0000000; op 05, a=-1, b=1 -> 1; op 06 same -> 0; op 1F -> 0.
